// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle sequencer: state enum,
// opcode values, ALU operations and immediate-format selects.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] opc);
        case (opc)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle in which the wait budget
// runs out while the access is still outstanding.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

    assign expired = en && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RISC-V style control sequencer. Define SEQ_ILLEGAL_TRAP_EN to
// halt with fault on unlisted opcodes; by default they decode as NOPs.
module mc_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       PCsrc,
    output logic       RegWrite,
    output logic       ALUsrc,
    output logic [2:0] ALUctrl,
    output logic [1:0] ImmSrc,
    output logic       halted,
    output logic       fault
);
    state_t state;
    logic   in_access, expired, taken;
    logic   unused_f3;

    assign unused_f3 = funct3[2];
    assign in_access = (state == FETCH) || (state == MEM);
    assign taken     = eq ^ funct3[0];

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (in_access && !mem_ready),
        .clr     (!in_access || mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            fault <= 1'b0;
        end else begin
            case (state)
                IDLE:  state <= FETCH;
                FETCH: begin
                    if (mem_ready)
                        state <= DECODE;
                    else if (expired) begin
                        state <= HALT;
                        fault <= 1'b1;
                    end
                end
                DECODE: begin
                    case (op)
                        OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL:
                            state <= EXEC;
                        OP_SYSTEM: state <= HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
                        default: begin
                            state <= HALT;
                            fault <= 1'b1;
                        end
`else
                        default: state <= FETCH;
`endif
                    endcase
                end
                EXEC: begin
                    case (op)
                        OP_R, OP_IMM, OP_JAL: state <= WB;
                        OP_LOAD, OP_STORE:    state <= MEM;
                        default:              state <= FETCH;
                    endcase
                end
                MEM: begin
                    // a completing access beats a timeout in the same cycle
                    if (mem_ready)
                        state <= (op == OP_LOAD) ? WB : FETCH;
                    else if (expired) begin
                        state <= HALT;
                        fault <= 1'b1;
                    end
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset silences them immediately.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        PCsrc    = 1'b0;
        RegWrite = 1'b0;
        ALUsrc   = 1'b0;
        ALUctrl  = ALU_ADD;
        ImmSrc   = (state == IDLE) ? IMM_I : imm_sel(op);
        halted   = (state == HALT);
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            EXEC: begin
                ALUsrc = !((op == OP_R) || (op == OP_BRANCH));
                case (op)
                    OP_R, OP_IMM: ALUctrl = {1'b0, funct3[1:0]};
                    OP_BRANCH:    ALUctrl = ALU_SUB;
                    default:      ALUctrl = ALU_ADD;
                endcase
                if ((op == OP_JAL) || ((op == OP_BRANCH) && taken)) begin
                    pc_we = 1'b1;
                    PCsrc = 1'b1;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (op == OP_STORE);
            end
            WB:      RegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule
